seq_right_shifter: RTL

SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/shift_r1_stage.sv | 22 ++
 rtl/seq_right_shifter.sv | 90 +++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types and defaults for the sequential right shifter.
// Used by seq_right_shifter and shift_r1_stage.
package shifter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic state_is_idle(input state_e s);
        return (s == IDLE);
    endfunction

    function automatic logic state_is_done(input state_e s);
        return (s == DONE);
    endfunction

endpackage

// File: rtl/shift_r1_stage.sv
// Combinational one-bit right shift with MSB fill.
// Define ARITH_SHIFT_EN for sign fill; otherwise the MSB is filled with zero.
module shift_r1_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic fill_bit;

`ifdef ARITH_SHIFT_EN
    assign fill_bit = din[WIDTH-1];
`else
    assign fill_bit = 1'b0;
`endif

    assign dout = {fill_bit, din[WIDTH-1:1]};

endmodule

// File: rtl/seq_right_shifter.sv
// Sequential right shifter: one bit per cycle, valid/ready on both sides.
// Build option: ARITH_SHIFT_EN selects arithmetic instead of logical shift.
module seq_right_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] datain,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shifted_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] data_shifted;

    shift_r1_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .din  (data_q),
        .dout (data_shifted)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = datain;
                    cnt_d   = shift_amt;
                    state_d = (shift_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = data_shifted;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= state_is_idle(state_d);
            out_valid_q <= state_is_done(state_d);
            busy_q      <= !state_is_idle(state_d);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign shifted_data = data_q;

endmodule
